// File: rtl/seq_magnitude_comparator_pkg.sv
// cmp_pkg: FSM state and comparison-result encodings shared by the magnitude comparator.
package cmp_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
   typedef enum logic [1:0] {CMP_NONE, CMP_LT, CMP_EQ, CMP_GT} cmp_res_t;
   function automatic cmp_res_t cmp_decode(logic [2:0] lt_eq_gt);
      return lt_eq_gt == 3'b100 ? CMP_LT : lt_eq_gt == 3'b001 ? CMP_GT : CMP_EQ;
   endfunction
endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if: operand and result valid/ready channels of the comparator.
interface seq_magnitude_comparator_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic             lt;
   logic             eq;
   logic             gt;
   modport master (output in_valid, a, b, signed_mode, out_ready,
                   input  in_ready, out_valid, lt, eq, gt);
   modport slave  (input  in_valid, a, b, signed_mode, out_ready,
                   output in_ready, out_valid, lt, eq, gt);
endinterface

// File: rtl/seq_magnitude_comparator_digit_compare.sv
// digit_compare: combinational one-hot unsigned compare of one DIGIT-bit slice.
module digit_compare #(parameter int DIGIT = 4) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   output logic             lt,
   output logic             eq,
   output logic             gt
);
   assign lt = x < y;
   assign eq = x == y;
   assign gt = x > y;
endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: MSB-digit-first multi-cycle magnitude compare with early exit.
module seq_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic                      clk,
   input logic                      rst,
   seq_magnitude_comparator_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (WIDTH % DIGIT != 0 || WIDTH < DIGIT) begin : g_bad_params
      $error("WIDTH must be a non-zero multiple of DIGIT");
   end

   state_t           state_q, state_d;
   cmp_res_t         res_q, res_d, digit_res;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sign_flip;
   logic [IW-1:0]    idx_q, idx_d;
   logic [DIGIT-1:0] dig_a, dig_b;
   logic             d_lt, d_eq, d_gt;

   // Flipping the operand MSB maps two's complement onto unsigned order,
   // so only the top digit ever sees the difference.
   assign sign_flip = WIDTH'(bus.signed_mode) << (WIDTH - 1);
   assign dig_a     = a_q[int'(idx_q)*DIGIT +: DIGIT];
   assign dig_b     = b_q[int'(idx_q)*DIGIT +: DIGIT];
   assign digit_res = cmp_decode({d_lt, d_eq, d_gt});

   digit_compare #(.DIGIT(DIGIT)) u_digit (
      .x (dig_a),
      .y (dig_b),
      .lt(d_lt),
      .eq(d_eq),
      .gt(d_gt)
   );

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: if (bus.in_valid) begin
            a_d     = bus.a ^ sign_flip;
            b_d     = bus.b ^ sign_flip;
            idx_d   = IW'(NDIG - 1);
            state_d = ST_RUN;
         end
         ST_RUN: if (digit_res != CMP_EQ || idx_q == '0) begin
            res_d   = digit_res;
            state_d = ST_DONE;
         end else begin
            idx_d = idx_q - IW'(1);
         end
         ST_DONE: if (bus.out_ready) begin
            res_d   = CMP_NONE;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         res_q   <= CMP_NONE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = state_q == ST_IDLE;
   assign bus.out_valid = state_q == ST_DONE;
   assign bus.lt        = res_q == CMP_LT;
   assign bus.eq        = res_q == CMP_EQ;
   assign bus.gt        = res_q == CMP_GT;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: three comparator configurations checked against an arithmetic model.
module tb_seq_magnitude_comparator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int W[3] = '{16, 8, 12};
   int D[3] = '{4, 8, 3};

   logic        iv[3], orr[3], sm[3];
   logic [31:0] av[3], bv[3];
   logic        ir[3], ov[3], lt[3], eq[3], gt[3];

   int tests = 0;
   int fails = 0;
   int ec = 0;
   always @(posedge clk) ec <= ec + 1;

   seq_magnitude_comparator_if #(.WIDTH(16)) bus0 ();
   seq_magnitude_comparator_if #(.WIDTH(8))  bus1 ();
   seq_magnitude_comparator_if #(.WIDTH(12)) bus2 ();

   assign bus0.in_valid = iv[0]; assign bus0.a = av[0][15:0]; assign bus0.b = bv[0][15:0];
   assign bus0.signed_mode = sm[0]; assign bus0.out_ready = orr[0];
   assign ir[0] = bus0.in_ready; assign ov[0] = bus0.out_valid;
   assign lt[0] = bus0.lt; assign eq[0] = bus0.eq; assign gt[0] = bus0.gt;

   assign bus1.in_valid = iv[1]; assign bus1.a = av[1][7:0]; assign bus1.b = bv[1][7:0];
   assign bus1.signed_mode = sm[1]; assign bus1.out_ready = orr[1];
   assign ir[1] = bus1.in_ready; assign ov[1] = bus1.out_valid;
   assign lt[1] = bus1.lt; assign eq[1] = bus1.eq; assign gt[1] = bus1.gt;

   assign bus2.in_valid = iv[2]; assign bus2.a = av[2][11:0]; assign bus2.b = bv[2][11:0];
   assign bus2.signed_mode = sm[2]; assign bus2.out_ready = orr[2];
   assign ir[2] = bus2.in_ready; assign ov[2] = bus2.out_valid;
   assign lt[2] = bus2.lt; assign eq[2] = bus2.eq; assign gt[2] = bus2.gt;

   seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) u0 (.clk(clk), .rst(rst), .bus(bus0));
   seq_magnitude_comparator #(.WIDTH(8),  .DIGIT(8)) u1 (.clk(clk), .rst(rst), .bus(bus1));
   seq_magnitude_comparator #(.WIDTH(12), .DIGIT(3)) u2 (.clk(clk), .rst(rst), .bus(bus2));

   task automatic chk(string n, longint act, longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, ec);
      end
   endtask

   // {lt,eq,gt} from plain integer comparison of the (sign-extended) values
   function automatic logic [2:0] m_res(longint unsigned a, longint unsigned b, int w, bit s);
      longint sa, sb;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      return sa < sb ? 3'b100 : sa == sb ? 3'b010 : 3'b001;
   endfunction

   // cycles from accept to result: leading equal digits + 1, capped at digit count
   function automatic int m_lat(longint unsigned a, longint unsigned b, int w, int d);
      int n, k;
      longint unsigned dm;
      n  = w / d;
      k  = 0;
      dm = (longint'(1) << d) - 1;
      for (int i = n - 1; i >= 0; i--) begin
         if (((a >> (i * d)) & dm) != ((b >> (i * d)) & dm)) break;
         k++;
      end
      return (k + 1 > n) ? n : k + 1;
   endfunction

   bit          busy[3];
   int          acc[3], elat[3];
   logic [2:0]  eres[3];

   always @(negedge clk) begin
      bit eov;
      longint unsigned msk;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            busy[i] = 1'b0;
            chk($sformatf("rst_ov%0d", i), ov[i], 0);
            chk($sformatf("rst_res%0d", i), {lt[i], eq[i], gt[i]}, 0);
         end else begin
            eov = busy[i] && (ec - acc[i] >= elat[i]);
            chk($sformatf("ov%0d", i), ov[i], eov);
            chk($sformatf("in_ready%0d", i), ir[i], !busy[i]);
            chk($sformatf("res%0d", i), {lt[i], eq[i], gt[i]}, eov ? eres[i] : 3'b000);
            if (ov[i] && orr[i]) busy[i] = 1'b0;
            if (iv[i] && ir[i]) begin
               msk     = (longint'(1) << W[i]) - 1;
               busy[i] = 1'b1;
               acc[i]  = ec + 1;
               eres[i] = m_res(av[i] & msk, bv[i] & msk, W[i], sm[i]);
               elat[i] = m_lat(av[i] & msk, bv[i] & msk, W[i], D[i]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(int s, logic [31:0] a, logic [31:0] b, bit smode, int gap, int hold, bit early,
                      output logic [2:0] res, output int lat);
      int n;
      repeat (gap) tick();
      av[s] = a;
      bv[s] = b;
      sm[s] = smode;
      iv[s] = 1'b1;
      n = 0;
      while (!ir[s] && n < 50) begin tick(); n++; end
      tick();
      iv[s] = 1'b0;
      av[s] = $urandom;
      bv[s] = $urandom;
      sm[s] = ~smode;
      if (early) orr[s] = 1'b1;
      lat = 0;
      while (!ov[s] && lat < 50) begin tick(); lat++; end
      chk($sformatf("timeout%0d", s), lat >= 50, 0);
      res = {lt[s], eq[s], gt[s]};
      repeat (hold) tick();
      orr[s] = 1'b1;
      tick();
      orr[s] = 1'b0;
   endtask

   task automatic rand_run(int s, int cnt);
      logic [31:0] ra, rb, msk;
      logic [2:0]  res;
      int          lat, r, hold;
      msk = (32'd1 << W[s]) - 1;
      for (int k = 0; k < cnt; k++) begin
         ra   = $urandom & msk;
         r    = $urandom_range(0, 3);
         rb   = r == 0 ? ra : r == 1 ? ra ^ (32'd1 << $urandom_range(0, W[s] - 1)) : $urandom;
         rb   = rb & msk;
         hold = $urandom_range(0, 3);
         txn(s, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), hold,
             hold == 0 && $urandom_range(0, 1) == 1, res, lat);
      end
   endtask

   initial begin
      #400000;
      fails++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      logic [2:0] res;
      int lat;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 0; orr[i] = 0; sm[i] = 0; av[i] = 0; bv[i] = 0;
      end
      #2;
      chk("reset_ov", ov[0], 0);
      chk("reset_res", {lt[0], eq[0], gt[0]}, 0);
      tick(); tick();
      rst = 1'b0;
      chk("reset_in_ready", ir[0], 1);

      chk("model_eq", m_res(16'h1234, 16'h1234, 16, 0), 3'b010);
      chk("model_eq_lat", m_lat(16'h1234, 16'h1234, 16, 4), 4);
      chk("model_signed", m_res(16'h8000, 16'h7FFF, 16, 1), 3'b100);
      chk("model_lat3", m_lat(16'h12A4, 16'h12B4, 16, 4), 3);

      txn(0, 16'h1234, 16'h1234, 0, 0, 0, 0, res, lat);
      chk("t1_res", res, 3'b010); chk("t1_lat", lat, 4);
      txn(0, 16'h8000, 16'h7FFF, 0, 1, 0, 0, res, lat);
      chk("t2u_res", res, 3'b001); chk("t2u_lat", lat, 1);
      txn(0, 16'h8000, 16'h7FFF, 1, 0, 0, 0, res, lat);
      chk("t2s_res", res, 3'b100); chk("t2s_lat", lat, 1);
      txn(0, 16'h12A4, 16'h12B4, 0, 0, 0, 1, res, lat);
      chk("t3u_res", res, 3'b100); chk("t3u_lat", lat, 3);
      txn(0, 16'hFFFF, 16'hFFFE, 1, 0, 0, 0, res, lat);
      chk("t3s_res", res, 3'b001); chk("t3s_lat", lat, 4);
      txn(0, 16'h0001, 16'h0002, 0, 0, 5, 0, res, lat);
      chk("t4_res", res, 3'b100); chk("t4_lat", lat, 4);
      chk("t4_in_ready", ir[0], 1);
      chk("t4_cleared", {ov[0], lt[0], eq[0], gt[0]}, 0);
      txn(1, 8'h05, 8'h05, 0, 0, 0, 0, res, lat);
      chk("w8_res", res, 3'b010); chk("w8_lat", lat, 1);

      av[0] = 16'h1234; bv[0] = 16'h1234; sm[0] = 0; iv[0] = 1;
      tick();
      iv[0] = 0;
      tick(); tick();
      rst = 1'b1;
      #1 chk("t5_rst_ov", ov[0], 0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("t5_no_result", ov[0], 0);
         tick();
      end
      chk("t5_in_ready", ir[0], 1);
      txn(0, 16'd3, 16'd5, 0, 0, 0, 0, res, lat);
      chk("t5_res", res, 3'b100); chk("t5_lat", lat, 4);

      fork
         rand_run(0, 40);
         rand_run(1, 60);
         rand_run(2, 60);
      join
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
